stage4_fast_message_serializer: RTL

- Downstream neighbour of the stage-3 fast message mux.
- Captures the three selected FAST-encoded fields (message_fast_1..3 with length_fast_1..3) as one message.
- Emits them as a byte stream, lane 1 then 2 then 3, on a valid/ready interface toward the stage-5 frame builder.
- Skips zero-length lanes, flags illegal lengths and counts emitted messages.

---
 rtl/stage4_fast_message_serializer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/stage4_fast_message_serializer.sv
// Stage-4 fast message serializer: captures three FAST lane fields as one
// message and streams their bytes (lane 1, 2, 3; MS byte first) on a
// valid/ready byte interface toward the stage-5 frame builder.
module stage4_fast_message_serializer #(
    parameter int FAST_MESSAGE_BITS = 64,
    parameter int FAST_LENGTH_BITS  = 4,
    parameter int MAX_BYTES         = FAST_MESSAGE_BITS / 8,
    parameter int CNT_BITS          = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [FAST_MESSAGE_BITS-1:0] message_fast_1,
    input  logic [FAST_MESSAGE_BITS-1:0] message_fast_2,
    input  logic [FAST_MESSAGE_BITS-1:0] message_fast_3,
    input  logic [FAST_LENGTH_BITS-1:0]  length_fast_1,
    input  logic [FAST_LENGTH_BITS-1:0]  length_fast_2,
    input  logic [FAST_LENGTH_BITS-1:0]  length_fast_3,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [7:0]                   out_data,
    output logic [1:0]                   out_lane,
    output logic                         out_sop,
    output logic                         out_eop,
    output logic                         len_err,
    output logic [CNT_BITS-1:0]          msg_cnt
);

    // State encoding doubles as the lane number being emitted.
    typedef enum logic [1:0] {IDLE = 2'd0, LANE1 = 2'd1, LANE2 = 2'd2, LANE3 = 2'd3} state_t;
    typedef logic [2:0][FAST_LENGTH_BITS-1:0]  lens_t;
    typedef logic [2:0][FAST_MESSAGE_BITS-1:0] msgs_t;

    localparam logic [FAST_LENGTH_BITS-1:0] MAX_LEN = FAST_LENGTH_BITS'(MAX_BYTES);

    state_t                      state_q, state_d;
    msgs_t                       msg_q, msg_d;
    lens_t                       len_q, len_d;
    logic [FAST_LENGTH_BITS-1:0] idx_q, idx_d;
    logic                        out_valid_q, out_valid_d;
    logic [7:0]                  out_data_q, out_data_d;
    logic [1:0]                  out_lane_q, out_lane_d;
    logic                        out_sop_q, out_sop_d;
    logic                        out_eop_q, out_eop_d;
    logic                        len_err_q, len_err_d;
    logic [CNT_BITS-1:0]         msg_cnt_q, msg_cnt_d;

    msgs_t                       msg_in;
    lens_t                       len_raw, len_eff, src_len;
    msgs_t                       src_msg;
    logic                        bad_len, accept, load, same_lane;
    logic [1:0]                  nxt_lane;
    logic [FAST_LENGTH_BITS-1:0] nxt_idx;

    // Lowest-numbered lane above 'after' with a non-zero length, 0 if none.
    function automatic logic [1:0] nz_after(input lens_t lens, input logic [1:0] after);
        logic [1:0] r;
        r = 2'd0;
        if (after < 2'd3 && lens[2] != '0) r = 2'd3;
        if (after < 2'd2 && lens[1] != '0) r = 2'd2;
        if (after == 2'd0 && lens[0] != '0) r = 2'd1;
        return r;
    endfunction

    // Byte number 'ix' (0 = least significant) of a lane field.
    function automatic logic [7:0] byte_of(input logic [FAST_MESSAGE_BITS-1:0] m,
                                           input logic [FAST_LENGTH_BITS-1:0] ix);
        logic [FAST_MESSAGE_BITS-1:0] s;
        s = m >> {ix, 3'b000};
        return s[7:0];
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign msg_in   = {message_fast_3, message_fast_2, message_fast_1};
    assign len_raw  = {length_fast_3, length_fast_2, length_fast_1};

    // Illegal lengths collapse to zero so the lane is simply skipped.
    always_comb begin
        bad_len = 1'b0;
        len_eff = len_raw;
        for (int i = 0; i < 3; i++) begin
            if (len_raw[i] > MAX_LEN) begin
                len_eff[i] = '0;
                bad_len    = 1'b1;
            end
        end
    end

    // Next-state: pick the next byte position (lane, index) and preload it
    // into the output registers so out_valid never depends on out_ready.
    always_comb begin
        state_d     = state_q;
        msg_d       = msg_q;
        len_d       = len_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_lane_d  = out_lane_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        len_err_d   = 1'b0;
        msg_cnt_d   = msg_cnt_q;
        src_len     = len_q;
        src_msg     = msg_q;
        load        = 1'b0;
        same_lane   = 1'b0;
        nxt_lane    = 2'd0;
        nxt_idx     = '0;

        if (state_q == IDLE) begin
            if (accept) begin
                msg_d     = msg_in;
                len_d     = len_eff;
                len_err_d = bad_len;
                src_len   = len_eff;
                src_msg   = msg_in;
                nxt_lane  = nz_after(len_eff, 2'd0);
                load      = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            load = 1'b1;
            if (out_eop_q) begin
                msg_cnt_d = msg_cnt_q + 1'b1;
            end else if (idx_q != '0) begin
                nxt_lane  = state_q;
                same_lane = 1'b1;
            end else begin
                nxt_lane  = nz_after(len_q, state_q);
            end
        end

        if (load) begin
            if (nxt_lane != 2'd0) begin
                nxt_idx     = same_lane ? idx_q - 1'b1 : src_len[nxt_lane - 2'd1] - 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = byte_of(src_msg[nxt_lane - 2'd1], nxt_idx);
                out_lane_d  = nxt_lane;
                out_sop_d   = (state_q == IDLE);
                out_eop_d   = (nxt_idx == '0) && (nz_after(src_len, nxt_lane) == 2'd0);
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = 8'd0;
                out_lane_d  = 2'd0;
                out_sop_d   = 1'b0;
                out_eop_d   = 1'b0;
            end
            state_d = state_t'(nxt_lane);
            idx_d   = nxt_idx;
        end
    end

    // State and output registers; reset aborts any message in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'd0;
            out_lane_q  <= 2'd0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            len_err_q   <= 1'b0;
            msg_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_lane_q  <= out_lane_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            len_err_q   <= len_err_d;
            msg_cnt_q   <= msg_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_lane  = out_lane_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign len_err   = len_err_q;
    assign msg_cnt   = msg_cnt_q;

endmodule
